// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: owns the fetch PC, drives a RAM with one-cycle
// synchronous read latency, buffers returned words with their PCs in a small
// prefetch FIFO and hands them to decode over valid/ready. Redirects flush
// everything buffered or in flight and restart fetch at the target.
// Optional feature macro: IFETCH_COUNT_EN adds a 32-bit completed-handshake
// counter on output fetch_count.
module instruction_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_raddr,
   input  logic [31:0] imem_dout,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
`ifdef IFETCH_COUNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          pend_valid_q, pend_valid_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];

   logic          issue, push, pop;
   logic [CW:0]   occupancy;

   // Low address bits of the redirect target are dropped by design.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign imem_raddr = fetch_pc_q;
   assign inst_valid = (count_q != '0);
   assign inst       = inst_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
   assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

   // Credits count the in-flight read so the FIFO can never overflow at capture.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, pend_valid_q};
   assign issue     = !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign push      = pend_valid_q && !redirect_valid;
   assign pop       = inst_valid && inst_ready;

   // Next-state: redirect flushes FIFO and in-flight read, else issue/capture/pop.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pend_valid_d = 1'b0;
      pend_pc_d    = pend_pc_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (issue) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 32'd4;
         end
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'h0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
      end
   end

   // FIFO storage; contents are only observed through a valid head.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= pend_pc_q;
         inst_mem_q[wr_ptr_q] <= imem_dout;
      end
   end

`ifdef IFETCH_COUNT_EN
   // Completed handshakes, including a pop in a redirect cycle.
   always_ff @(posedge clk) begin
      if (reset)    fetch_count <= 32'h0;
      else if (pop) fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: directed scenarios push the
// PCs they expect decode to receive; a negedge monitor pops and compares on
// every handshake. Optional feature macro: IFETCH_COUNT_EN.
module tb_instruction_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_raddr;
   logic [31:0] imem_dout;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
`ifdef IFETCH_COUNT_EN
   logic [31:0] fetch_count;
`endif

   int checks = 0;
   int fails  = 0;
   logic [31:0] sb [$];

   instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_raddr     (imem_raddr),
      .imem_dout      (imem_dout),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
`ifdef IFETCH_COUNT_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   // Instruction RAM content as a fixed function of the word address.
   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // One-cycle synchronous-read RAM.
   always @(posedge clk) imem_dout <= ram_word(imem_raddr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every handshake must match the oldest expected PC.
   always @(negedge clk) begin
      if (!reset && inst_valid && inst_ready) begin
         if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_handshake: got pc %h expected none", inst_pc);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("sb_pc", inst_pc, e);
            chk("sb_inst", inst, ram_word(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Leaves the bench 1 time unit into cycle 0 (first cycle with reset low).
   task automatic do_reset();
      inst_ready = 1'b0; redirect_valid = 1'b0; reset = 1'b1;
      tick(); tick();
      chk("rst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_raddr", imem_raddr, 32'h0);
`ifdef IFETCH_COUNT_EN
      chk("rst_fcount", fetch_count, 32'h0);
`endif
      chk("sb_drained", sb.size(), 0);
      sb.delete();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;

      // Stream from reset with decode always ready.
      do_reset(); inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) sb.push_back(32'(4 * i));
      chk("s1_raddr_c0", imem_raddr, 32'h0);
      chk("s1_valid_c0", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s1_valid_c1", {31'h0, inst_valid}, 32'h0);
      for (int c = 2; c <= 9; c++) begin
         tick(); chk("s1_nogap", {31'h0, inst_valid}, 32'h1);
      end
      tick();

      // Backpressure for 10 cycles, then release.
      do_reset();
      tick(); tick();
      chk("s2_valid_c2", {31'h0, inst_valid}, 32'h1);
      chk("s2_pc_c2", inst_pc, 32'h0);
      tick(); tick(); tick();
      chk("s2_raddr_c5", imem_raddr, 32'h10);
      tick(); tick(); tick(); tick();
      chk("s2_raddr_c9", imem_raddr, 32'h10);
      chk("s2_head_c9", inst_pc, 32'h0);
      tick();
      inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) sb.push_back(32'(4 * i));
      for (int c = 10; c <= 15; c++) begin
         chk("s2_nogap", {31'h0, inst_valid}, 32'h1);
         tick();
      end

      // Redirect with 2 buffered and 1 in flight.
      do_reset();
      tick(); tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h3DE;
      tick();
      redirect_valid = 1'b0; inst_ready = 1'b1;
      sb.push_back(32'h3DC); sb.push_back(32'h3E0); sb.push_back(32'h3E4);
      chk("s3_raddr", imem_raddr, 32'h3DC);
      chk("s3_valid_r1", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s3_valid_r2", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s3_valid_r3", {31'h0, inst_valid}, 32'h1);
      chk("s3_pc_r3", inst_pc, 32'h3DC);
      tick(); tick(); tick();

      // Redirect in the same cycle as the pop of 0x8.
      do_reset(); inst_ready = 1'b1;
      sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
      sb.push_back(32'h100); sb.push_back(32'h104);
      tick(); tick(); tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick(); redirect_valid = 1'b0;
      chk("s4_valid_r1", {31'h0, inst_valid}, 32'h0);
`ifdef IFETCH_COUNT_EN
      chk("s4_fcount3", fetch_count, 32'd3);
`endif
      tick(); chk("s4_valid_r2", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s4_pc_r3", inst_pc, 32'h100);
      tick(); tick();
`ifdef IFETCH_COUNT_EN
      chk("s4_fcount5", fetch_count, 32'd5);
`endif

      // Reset (with a competing redirect) while the FIFO is full.
      do_reset();
      tick(); tick(); tick(); tick(); tick();
      chk("s5_full_head", inst_pc, 32'h0);
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h700;
      tick();
      reset = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
      sb.push_back(32'h0); sb.push_back(32'h4);
      chk("s5_valid_d0", {31'h0, inst_valid}, 32'h0);
      chk("s5_raddr_d0", imem_raddr, 32'h0);
      tick(); chk("s5_valid_d1", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s5_valid_d2", {31'h0, inst_valid}, 32'h1);
      chk("s5_pc_d2", inst_pc, 32'h0);
      tick(); tick();

      // Back-to-back redirects: the last one wins.
      do_reset(); inst_ready = 1'b1;
      sb.push_back(32'h0); sb.push_back(32'h600); sb.push_back(32'h604);
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h500;
      tick(); redirect_pc = 32'h600;
      tick(); redirect_valid = 1'b0;
      chk("s6_raddr", imem_raddr, 32'h600);
      chk("s6_valid_r1", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s6_valid_r2", {31'h0, inst_valid}, 32'h0);
      tick(); chk("s6_pc_r3", inst_pc, 32'h600);
      tick(); tick();

      // PC wrap past the top of the address space.
      do_reset(); inst_ready = 1'b1;
      sb.push_back(32'h0); sb.push_back(32'hFFFF_FFFC);
      sb.push_back(32'h0); sb.push_back(32'h4);
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick(); redirect_valid = 1'b0;
      tick(); tick(); chk("s7_pc_top", inst_pc, 32'hFFFF_FFFC);
      tick(); chk("s7_pc_wrap", inst_pc, 32'h0);
      tick(); tick();
      inst_ready = 1'b0;
      tick();
      chk("sb_final_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
